// File: rtl/mem_responder_pkg.sv
// Shared constants and FSM state type for the memory responder.
package mem_responder_pkg;

  localparam int unsigned AW_DEF = 11;
  localparam int unsigned DW_DEF = 32;

  localparam logic [10:0] ADDR_DISP = 11'h7FF;
  localparam logic [10:0] ADDR_SW   = 11'h7FE;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mem_responder_if.sv
// Single-word req/ack memory bus between the core (master) and the responder (slave).
interface mem_responder_if
  import mem_responder_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) ();

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;
  logic          busy;

  modport master (output req, we, addr, wdata, input  ack, rdata, busy);
  modport slave  (input  req, we, addr, wdata, output ack, rdata, busy);

endinterface

// File: rtl/mem_responder_word_ram.sv
// Single-port word RAM, synchronous read-first registered read, no reset.
module mem_responder_word_ram
  import mem_responder_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory responder: req/ack FSM with fixed wait states, word RAM, display mailbox
// at ADDR_DISP and a synchronised read-only switch port at ADDR_SW.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned AW          = AW_DEF,
  parameter int unsigned DW          = DW_DEF,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_responder_if.slave       bus,
  input  logic [7:0]           switch_i,
  output logic [DW-1:0]        disp_word_o
);

  localparam logic [AW-1:0] DISP_A   = AW'(ADDR_DISP);
  localparam logic [AW-1:0] SW_A     = AW'(ADDR_SW);
  localparam logic [3:0]    CNT_INIT = 4'(WAIT_CYCLES);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          ack_q, ack_d;
  logic          busy_q, busy_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [DW-1:0] disp_q, disp_d;
  logic [7:0]    sw_s1_q, sw_s2_q;

  logic [AW-1:0] ram_addr_c;
  logic          ram_we_c;
  logic          rd_ram_c;
  logic [DW-1:0] ram_rdata;

  mem_responder_word_ram #(.AW(AW), .DW(DW)) u_ram (
    .clk     (clk),
    .we_i    (ram_we_c),
    .addr_i  (ram_addr_c),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  // Next-state, access decode and output register inputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    disp_d     = disp_q;
    ram_addr_c = addr_q;

    case (state_q)
      S_IDLE: begin
        // RAM read is launched on the acceptance edge so data is ready in RESP.
        ram_addr_c = bus.addr;
        if (bus.req) begin
          addr_d  = bus.addr;
          we_d    = bus.we;
          wdata_d = bus.wdata;
          cnt_d   = CNT_INIT;
          state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ram_we_c = (state_q == S_RESP) && we_q && (addr_q != SW_A);
    rd_ram_c = (state_q == S_RESP) && !we_q && (addr_q != DISP_A) && (addr_q != SW_A);

    // MMIO reads resolve on entry to RESP; RAM reads are held after RESP ends.
    if ((state_d == S_RESP) && (state_q != S_RESP) && !we_d) begin
      if (addr_d == DISP_A) begin
        rdata_d = disp_q;
      end else if (addr_d == SW_A) begin
        rdata_d = DW'(sw_s2_q);
      end
    end
    if (rd_ram_c) begin
      rdata_d = ram_rdata;
    end

    if ((state_q == S_RESP) && we_q && (addr_q == DISP_A)) begin
      disp_d = wdata_q;
    end

    ack_d  = (state_d == S_RESP);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
      disp_q  <= '0;
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
      disp_q  <= disp_d;
      sw_s1_q <= switch_i;
      sw_s2_q <= sw_s1_q;
    end
  end

  assign bus.ack     = ack_q;
  assign bus.busy    = busy_q;
  assign bus.rdata   = rd_ram_c ? ram_rdata : rdata_q;
  assign disp_word_o = disp_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomised bench for mem_responder: a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance
// checked against a transaction-level model (word map, mailbox, switch port).
module tb_mem_responder;

  localparam int unsigned W_M = 2;
  localparam int unsigned W_Z = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  sw  = 8'h00;
  logic [31:0] disp_m, disp_z;

  mem_responder_if #(.AW(11), .DW(32)) bus_m ();
  mem_responder_if #(.AW(11), .DW(32)) bus_z ();

  mem_responder #(.AW(11), .DW(32), .WAIT_CYCLES(W_M)) dut_m (
    .clk (clk), .rst (rst), .bus (bus_m), .switch_i (sw), .disp_word_o (disp_m)
  );
  mem_responder #(.AW(11), .DW(32), .WAIT_CYCLES(W_Z)) dut_z (
    .clk (clk), .rst (rst), .bus (bus_z), .switch_i (sw), .disp_word_o (disp_z)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: word map per instance (key = sel*4096 + addr), mailbox, last read.
  logic [31:0] mdl_mem [int];
  logic [31:0] mdl_disp [2];
  logic [31:0] mdl_last [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drv(input int sel, input bit r, input bit w, input logic [10:0] a,
                     input logic [31:0] d);
    if (sel == 0) begin
      bus_m.req = r; bus_m.we = w; bus_m.addr = a; bus_m.wdata = d;
    end else begin
      bus_z.req = r; bus_z.we = w; bus_z.addr = a; bus_z.wdata = d;
    end
  endtask

  function automatic logic ack_of(input int sel);
    return (sel == 0) ? bus_m.ack : bus_z.ack;
  endfunction
  function automatic logic busy_of(input int sel);
    return (sel == 0) ? bus_m.busy : bus_z.busy;
  endfunction
  function automatic logic [31:0] rdata_of(input int sel);
    return (sel == 0) ? bus_m.rdata : bus_z.rdata;
  endfunction
  function automatic logic [31:0] disp_of(input int sel);
    return (sel == 0) ? disp_m : disp_z;
  endfunction

  // Model of one transaction: returns the rdata expected in the ack cycle.
  function automatic logic [31:0] model_txn(input int sel, input bit w, input logic [10:0] a,
                                            input logic [31:0] d);
    int k = sel * 4096 + int'(a);
    if (w) begin
      if (a == 11'h7FF) begin
        mdl_mem[k]    = d;
        mdl_disp[sel] = d;
      end else if (a != 11'h7FE) begin
        mdl_mem[k] = d;
      end
      return mdl_last[sel];
    end
    if (a == 11'h7FF)      mdl_last[sel] = mdl_disp[sel];
    else if (a == 11'h7FE) mdl_last[sel] = {24'h0, sw};
    else                   mdl_last[sel] = mdl_mem.exists(k) ? mdl_mem[k] : 32'hxxxx_xxxx;
    return mdl_last[sel];
  endfunction

  // One full transaction with latency, rdata, ack-pulse and mailbox checks.
  task automatic txn(input int sel, input bit w, input logic [10:0] a, input logic [31:0] d);
    int          lat = 0;
    bit          got = 1'b0;
    logic [31:0] exp;
    int          exp_lat = (sel == 0) ? int'(W_M) + 1 : int'(W_Z) + 1;
    @(negedge clk);
    drv(sel, 1'b1, w, a, d);
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) check("busy_after_accept", 32'(busy_of(sel)), 32'd1);
      if (ack_of(sel)) got = 1'b1;
    end
    check("ack_latency", 32'(lat), 32'(exp_lat));
    exp = model_txn(sel, w, a, d);
    if (got) check(w ? "rdata_hold_on_write" : "read_data", rdata_of(sel), exp);
    // Scramble the request lines after ack; latched values must be unaffected.
    drv(sel, 1'b0, 1'($urandom), 11'($urandom), $urandom);
    @(posedge clk); #1;
    check("ack_single_pulse", 32'(ack_of(sel)), 32'd0);
    check("disp_word", disp_of(sel), mdl_disp[sel]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          t_prev, t_now, cyc;
    bit          got;
    logic [31:0] d;
    logic [10:0] a;

    drv(0, 1'b0, 1'b0, 11'h0, 32'h0);
    drv(1, 1'b0, 1'b0, 11'h0, 32'h0);
    mdl_disp = '{32'h0, 32'h0};
    mdl_last = '{32'h0, 32'h0};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(bus_m.ack), 32'd0);
    check("rst_busy", 32'(bus_m.busy), 32'd0);
    check("rst_rdata", bus_m.rdata, 32'h0);
    check("rst_disp", disp_m, 32'h0);
    rst = 1'b1;

    // Write then read a RAM word.
    txn(0, 1'b1, 11'h010, 32'h0000_1234);
    txn(0, 1'b0, 11'h010, 32'h0);

    // Mailbox write: disp_word follows one cycle after ack; read back.
    txn(0, 1'b1, 11'h7FF, 32'hDEAD_BEEF);
    txn(0, 1'b0, 11'h7FF, 32'h0);

    // Switch port read, and a write to it is ignored.
    @(negedge clk); sw = 8'hA5;
    repeat (3) @(negedge clk);
    txn(0, 1'b0, 11'h7FE, 32'h0);
    txn(0, 1'b1, 11'h7FE, 32'hFFFF_FFFF);
    txn(0, 1'b0, 11'h7FE, 32'h0);

    // Back-to-back reads with req held high.
    for (int i = 0; i < 4; i++) txn(0, 1'b1, 11'(i), $urandom);
    @(negedge clk);
    drv(0, 1'b1, 1'b0, 11'h000, 32'h0);
    cyc = 0; t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      got = 1'b0;
      while (!got && cyc < 200) begin
        @(posedge clk); #1;
        cyc++;
        if (bus_m.ack) got = 1'b1;
      end
      t_now = cyc;
      check("b2b_ack_seen", 32'(got), 32'd1);
      if (i > 0) check("b2b_spacing", 32'(t_now - t_prev), 32'(W_M + 2));
      check("b2b_rdata", bus_m.rdata, model_txn(0, 1'b0, 11'(i), 32'h0));
      t_prev = t_now;
      if (i < 3) bus_m.addr = 11'(i + 1);
      else       bus_m.req  = 1'b0;
    end
    @(posedge clk); #1;
    check("b2b_ack_drop", 32'(bus_m.ack), 32'd0);

    // Reset in WAIT aborts a write.
    txn(0, 1'b1, 11'h020, 32'h0000_00AA);
    txn(0, 1'b0, 11'h7FF, 32'h0);
    @(negedge clk);
    drv(0, 1'b1, 1'b1, 11'h020, 32'h0000_0055);
    @(posedge clk); #1;
    check("abort_busy", 32'(bus_m.busy), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    drv(0, 1'b0, 1'b0, 11'h0, 32'h0);
    #1;
    check("abort_ack", 32'(bus_m.ack), 32'd0);
    check("abort_busy_clr", 32'(bus_m.busy), 32'd0);
    check("abort_rdata", bus_m.rdata, 32'h0);
    check("abort_disp", disp_m, 32'h0);
    mdl_disp = '{32'h0, 32'h0};
    mdl_last = '{32'h0, 32'h0};
    @(negedge clk);
    rst = 1'b1;
    got = 1'b0;
    repeat (4) begin @(posedge clk); #1; if (bus_m.ack) got = 1'b1; end
    check("abort_no_ack", 32'(got), 32'd0);
    txn(0, 1'b0, 11'h020, 32'h0);
    txn(0, 1'b0, 11'h7FF, 32'h0);

    // Zero-wait instance: ack one cycle after acceptance.
    txn(1, 1'b1, 11'h100, 32'h0BAD_F00D);
    txn(1, 1'b0, 11'h100, 32'h0);
    txn(1, 1'b0, 11'h7FE, 32'h0);
    txn(1, 1'b1, 11'h7FF, 32'h1357_9BDF);

    // Randomised mix on both instances over a small pre-written window.
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 16; i++) txn(s, 1'b1, 11'(i), $urandom);
    for (int i = 0; i < 60; i++) begin
      int s = int'($urandom_range(1, 0));
      int p = int'($urandom_range(5, 0));
      if ($urandom_range(7, 0) == 0) begin
        @(negedge clk); sw = 8'($urandom);
        repeat (3) @(negedge clk);
      end
      a = (p == 0) ? 11'h7FF : (p == 1) ? 11'h7FE : 11'($urandom_range(15, 0));
      d = $urandom;
      txn(s, 1'($urandom), a, d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
